spi_slave_echo: RTL and testbench
=================================

// Module: spi_slave_echo
// PURPOSE
//  Parametrised SPI slave with integrated input conditioning and echo buffer.
//  Receives PACKET_BYTES*BYTE_SIZE-bit frames MSB-first in any of the four SPI
//  modes, presents each completed frame on dataOut with a 1-cycle strobe, and
//  shifts the last completed frame back out on MISO during the next frame.
//  Used as a board-level link test and as the host port in front of the FIR.
// PARAMETERS
//  PACKET_BYTES  8  bytes per frame (1..16)
//  BYTE_SIZE     8  bits per byte
//  CPOL          0  idle level of SCK
//  CPHA          0  0: sample on leading edge, shift on trailing; 1: reverse
// PORTS
//  clkIn            in   1    system clock; must be >= 8x SCK frequency
//  resetIn          in   1    asynchronous, active-high reset
//  ssIn             in   1    raw slave select, active low
//  sckIn            in   1    raw SPI clock
//  mosiIn           in   1    raw MOSI
//  misoOut          out  1    MISO, registered
//  dataOut          out  W    last completed frame, W = PACKET_BYTES*BYTE_SIZE
//  dataReceivedOut  out  1    1-cycle strobe, dataOut updated this cycle
//  busyOut          out  1    1 while filtered ss is low
//  frameErrorOut    out  1    sticky frame-abort flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: misoOut=0, dataOut=0, dataReceivedOut=0, busyOut=0,
//    frameErrorOut=0, echo register=0, bit counter=0, state IDLE.
//  - Each raw input: 2-FF synchroniser then registered majority-of-3 vote;
//    input-to-filtered latency 4 clkIn cycles; pulses <2 cycles are rejected.
//  - Edges are detected on filtered SCK; sample/shift edge chosen by CPOL/CPHA.
//  - FSM: IDLE -(ss fall)-> LOAD -(1 cycle)-> SHIFT -(ss rise)-> IDLE.
//    LOAD copies echo register into tx shifter and drives its MSB onto MISO
//    (CPHA=0 requires the first bit valid before the first edge).
//  - SHIFT: sample edge shifts mosi into rx shifter, increments bit counter;
//    shift edge advances tx shifter, misoOut <= next bit.
//  - Counter reaching W-1 on a sample edge: counter wraps to 0, dataOut and
//    echo register <= completed rx word, dataReceivedOut=1 the next cycle;
//    tx shifter reloads from completed word (bypass), so back-to-back frames
//    without ss deassertion echo the immediately preceding frame.
//  - ss rise with counter != 0: partial bits discarded, dataOut unchanged,
//    no strobe; counter cleared. SCK edges in IDLE are ignored.
//  - misoOut = 0 in IDLE. Reset mid-frame aborts immediately; no strobe.
// CONFIGURATION
//  SPI_FRAME_ERROR_EN defined: ss rise with counter != 0 sets frameErrorOut;
//    cleared by reset or the next completed frame's strobe.
//  Not defined: abort detection logic removed, frameErrorOut tied 0.
// STRUCTURE
//  Package spi_pkg: state enum (IDLE, LOAD, SHIFT), mode-to-edge helper
//    function, frame width constant function.
//  Sub-module spi_input_filter: 2-FF sync + majority-3, instantiated x3.
// TESTING
//  1. Mode 0, send 0x0123456789ABCDEF -> dataOut=0x0123456789ABCDEF, one strobe;
//     next frame MISO returns 0x0123456789ABCDEF, first frame MISO all 0.
//  2. Modes 1/2/3, send 0xA5C3_0000_FFFF_5A3C -> identical capture and echo.
//  3. Two frames back-to-back in one ss window (0x11.., 0x22..) -> two strobes;
//     second frame MISO = first frame data.
//  4. ss rises after 13 bits -> no strobe, dataOut unchanged; with
//     SPI_FRAME_ERROR_EN frameErrorOut=1 until next good frame.
//  5. 1-cycle glitches on sckIn during SHIFT -> no extra bits, data intact.
//  6. resetIn pulsed after 30 bits -> all outputs 0; next full frame correct.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI echo slave: FSM state encoding,
// SPI-mode edge selection and frame width.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_t;

    // Data is sampled on the rising SCK edge exactly when CPOL equals CPHA.
    function automatic logic sample_on_rising(input logic cpol, input logic cpha);
        return (cpol == cpha);
    endfunction

    function automatic int frame_width(input int packetBytes, input int byteSize);
        return packetBytes * byteSize;
    endfunction

endpackage

// File: rtl/spi_input_filter.sv
// Input conditioner for one raw SPI pin: 2-FF synchroniser followed by a
// registered majority-of-3 vote (4-cycle latency, rejects 1-cycle pulses).
module spi_input_filter #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clkIn,
    input  logic resetIn,
    input  logic rawIn,
    output logic filteredOut
);

    logic [1:0] r_sync;
    logic [1:0] r_hist;
    logic       r_filtered;

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_sync     <= {2{RESET_VAL}};
            r_hist     <= {2{RESET_VAL}};
            r_filtered <= RESET_VAL;
        end else begin
            r_sync     <= {r_sync[0], rawIn};
            r_hist     <= {r_hist[0], r_sync[1]};
            r_filtered <= (r_sync[1] & r_hist[0]) |
                          (r_sync[1] & r_hist[1]) |
                          (r_hist[0] & r_hist[1]);
        end
    end

    assign filteredOut = r_filtered;

endmodule

// File: rtl/spi_slave_echo.sv
// SPI slave that captures MSB-first frames and echoes the previous frame on MISO.
// Optional macro SPI_FRAME_ERROR_EN enables the sticky frame-abort flag.
module spi_slave_echo
    import spi_pkg::*;
#(
    parameter int PACKET_BYTES = 8,
    parameter int BYTE_SIZE    = 8,
    parameter bit CPOL         = 1'b0,
    parameter bit CPHA         = 1'b0
) (
    input  logic                                           clkIn,
    input  logic                                           resetIn,
    input  logic                                           ssIn,
    input  logic                                           sckIn,
    input  logic                                           mosiIn,
    output logic                                           misoOut,
    output logic [frame_width(PACKET_BYTES, BYTE_SIZE)-1:0] dataOut,
    output logic                                           dataReceivedOut,
    output logic                                           busyOut,
    output logic                                           frameErrorOut
);

    localparam int              W           = frame_width(PACKET_BYTES, BYTE_SIZE);
    localparam int              CW          = $clog2(W);
    localparam logic [CW-1:0]   LAST_BIT    = CW'(W - 1);
    localparam bit              SAMPLE_RISE = sample_on_rising(CPOL, CPHA);

    logic w_ss;
    logic w_sck;
    logic w_mosi;

    spi_input_filter #(.RESET_VAL(1'b1)) u_ssFilter (
        .clkIn(clkIn), .resetIn(resetIn), .rawIn(ssIn), .filteredOut(w_ss)
    );
    spi_input_filter #(.RESET_VAL(CPOL)) u_sckFilter (
        .clkIn(clkIn), .resetIn(resetIn), .rawIn(sckIn), .filteredOut(w_sck)
    );
    spi_input_filter #(.RESET_VAL(1'b0)) u_mosiFilter (
        .clkIn(clkIn), .resetIn(resetIn), .rawIn(mosiIn), .filteredOut(w_mosi)
    );

    spi_state_t    r_state;
    spi_state_t    w_stateNext;
    logic          r_sckPrev;
    logic          r_ssPrev;
    logic [W-2:0]  r_rx;
    logic [W-1:0]  r_txWord;
    logic [W-1:0]  r_echo;
    logic [W-1:0]  r_data;
    logic [CW-1:0] r_cnt;
    logic          r_miso;
    logic          r_dataRecv;

    logic          w_load;
    logic          w_active;
    logic          w_sampleEdge;
    logic          w_shiftEdge;
    logic          w_complete;
    logic [W-1:0]  w_rxNext;
    logic [CW-1:0] w_txIdx;

    assign w_sampleEdge = SAMPLE_RISE ? (w_sck & ~r_sckPrev) : (~w_sck & r_sckPrev);
    assign w_shiftEdge  = SAMPLE_RISE ? (~w_sck & r_sckPrev) : (w_sck & ~r_sckPrev);
    assign w_rxNext     = {r_rx, w_mosi};
    assign w_complete   = w_active & w_sampleEdge & (r_cnt == LAST_BIT);
    // MISO bit is picked by how many bits of the current frame have been sampled,
    // which covers both CPHA settings and the back-to-back reload.
    assign w_txIdx      = LAST_BIT - r_cnt;

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (r_ssPrev && !w_ss) w_stateNext = LOAD;
            LOAD:    w_stateNext = SHIFT;
            SHIFT:   if (w_ss) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_active = 1'b0;
        case (r_state)
            LOAD:    w_load   = 1'b1;
            SHIFT:   w_active = !w_ss;
            default: ;
        endcase
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_sckPrev  <= CPOL;
            r_ssPrev   <= 1'b1;
            r_rx       <= '0;
            r_txWord   <= '0;
            r_echo     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_miso     <= 1'b0;
            r_dataRecv <= 1'b0;
        end else begin
            r_sckPrev  <= w_sck;
            r_ssPrev   <= w_ss;
            r_dataRecv <= w_complete;
            if (w_load) begin
                r_txWord <= r_echo;
                r_miso   <= r_echo[W-1];
                r_cnt    <= '0;
            end else if (w_active) begin
                if (w_sampleEdge) begin
                    r_rx <= w_rxNext[W-2:0];
                    if (w_complete) begin
                        r_cnt    <= '0;
                        r_data   <= w_rxNext;
                        r_echo   <= w_rxNext;
                        r_txWord <= w_rxNext;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                if (w_shiftEdge) begin
                    r_miso <= r_txWord[w_txIdx];
                end
            end else begin
                r_cnt  <= '0;
                r_miso <= 1'b0;
            end
        end
    end

`ifdef SPI_FRAME_ERROR_EN
    logic r_frameErr;
    logic w_abort;

    assign w_abort = (r_state == SHIFT) && w_ss && (r_cnt != '0);

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_frameErr <= 1'b0;
        end else if (w_abort) begin
            r_frameErr <= 1'b1;
        end else if (w_complete) begin
            r_frameErr <= 1'b0;
        end
    end

    assign frameErrorOut = r_frameErr;
`else
    assign frameErrorOut = 1'b0;
`endif

    assign misoOut         = r_miso;
    assign dataOut         = r_data;
    assign dataReceivedOut = r_dataRecv;
    assign busyOut         = ~w_ss;

endmodule

// File: tb/tb_spi_slave_echo.sv
// Bench for spi_slave_echo: one instance per SPI mode driven by a bit-level
// master, compared against a frame-level model of received and echoed words.
module tb_spi_slave_echo;

    localparam int W      = 64;
    localparam int HALF   = 8;
    localparam int SS_GAP = 16;

`ifdef SPI_FRAME_ERROR_EN
    localparam logic EXP_ABORT_FLAG = 1'b1;
`else
    localparam logic EXP_ABORT_FLAG = 1'b0;
`endif

    logic         clkIn = 1'b0;
    logic         resetIn;
    logic [3:0]   ssIn;
    logic [3:0]   sckIn;
    logic         mosiIn;
    wire  [3:0]   misoOut;
    wire  [3:0]   dataReceivedOut;
    wire  [3:0]   busyOut;
    wire  [3:0]   frameErrorOut;
    wire  [W-1:0] dataOut [4];

    int checkCount  = 0;
    int passCount   = 0;
    int failCount   = 0;
    int strobeCount = 0;

    logic [W-1:0] echoModel [4];
    logic [W-1:0] dataModel [4];

    always #5 clkIn = ~clkIn;

    for (genvar m = 0; m < 4; m++) begin : g_dut
        spi_slave_echo #(
            .PACKET_BYTES(8),
            .BYTE_SIZE(8),
            .CPOL(1'(m / 2)),
            .CPHA(1'(m % 2))
        ) dut (
            .clkIn(clkIn),
            .resetIn(resetIn),
            .ssIn(ssIn[m]),
            .sckIn(sckIn[m]),
            .mosiIn(mosiIn),
            .misoOut(misoOut[m]),
            .dataOut(dataOut[m]),
            .dataReceivedOut(dataReceivedOut[m]),
            .busyOut(busyOut[m]),
            .frameErrorOut(frameErrorOut[m])
        );
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int mode);
        @(posedge clkIn);
        #1;
        if (dataReceivedOut[mode] === 1'b1) strobeCount++;
    endtask

    task automatic waitHalf(input int mode, input bit glitch);
        for (int c = 0; c < HALF; c++) begin
            if (glitch && (c == 3 || c == 4)) sckIn[mode] = ~sckIn[mode];
            tick(mode);
        end
    endtask

    task automatic selectSlave(input int mode);
        ssIn[mode] = 1'b0;
        repeat (SS_GAP) tick(mode);
    endtask

    task automatic deselectSlave(input int mode);
        ssIn[mode] = 1'b1;
        repeat (SS_GAP) tick(mode);
    endtask

    // Master side: shifts nBits from the top of bits, capturing MISO where the master samples.
    task automatic applyStimulus(input int mode, input logic [127:0] bits, input int nBits,
                                 input bit glitch, output logic [127:0] misoBits);
        logic cpol;
        logic cpha;
        cpol     = 1'((mode >> 1) & 1);
        cpha     = 1'(mode & 1);
        misoBits = '0;
        for (int i = 0; i < nBits; i++) begin
            if (!cpha) begin
                mosiIn = bits[127 - i];
                waitHalf(mode, glitch);
                misoBits = {misoBits[126:0], misoOut[mode]};
                sckIn[mode] = ~cpol;
                waitHalf(mode, glitch);
                sckIn[mode] = cpol;
            end else begin
                sckIn[mode] = ~cpol;
                mosiIn = bits[127 - i];
                waitHalf(mode, glitch);
                misoBits = {misoBits[126:0], misoOut[mode]};
                sckIn[mode] = cpol;
                waitHalf(mode, glitch);
            end
        end
        waitHalf(mode, 1'b0);
    endtask

    task automatic runFrame(input int mode, input logic [W-1:0] word, input bit glitch,
                            input string tag);
        logic [127:0] miso;
        strobeCount = 0;
        selectSlave(mode);
        applyStimulus(mode, {word, 64'h0}, W, glitch, miso);
        deselectSlave(mode);
        checkOutput($sformatf("%s m%0d echo", tag, mode), 128'(miso[63:0]), 128'(echoModel[mode]));
        checkOutput($sformatf("%s m%0d strobes", tag, mode), 128'(strobeCount), 128'(1));
        dataModel[mode] = word;
        echoModel[mode] = word;
        checkOutput($sformatf("%s m%0d data", tag, mode), 128'(dataOut[mode]), 128'(dataModel[mode]));
    endtask

    initial begin
        logic [127:0] miso;
        logic [W-1:0] rw;
        int           rm;

        for (int m = 0; m < 4; m++) begin
            echoModel[m] = '0;
            dataModel[m] = '0;
        end
        resetIn = 1'b1;
        ssIn    = 4'hF;
        sckIn   = 4'b1100;
        mosiIn  = 1'b0;
        repeat (3) @(posedge clkIn);
        #1;
        checkOutput("reset miso", 128'(misoOut[0]), 128'(0));
        checkOutput("reset data", 128'(dataOut[0]), 128'(0));
        checkOutput("reset strobe", 128'(dataReceivedOut[0]), 128'(0));
        checkOutput("reset busy", 128'(busyOut[0]), 128'(0));
        checkOutput("reset frameErr", 128'(frameErrorOut[0]), 128'(0));
        resetIn = 1'b0;
        repeat (4) tick(0);

        $display("[TB] mode 0 capture and echo");
        runFrame(0, 64'h0123456789ABCDEF, 1'b0, "first");
        runFrame(0, {$urandom(), $urandom()}, 1'b0, "second");

        $display("[TB] modes 1-3 capture and echo");
        for (int m = 1; m < 4; m++) begin
            runFrame(m, 64'hA5C3_0000_FFFF_5A3C, 1'b0, "pattern");
            runFrame(m, {$urandom(), $urandom()}, 1'b0, "follow");
        end

        $display("[TB] back-to-back frames");
        strobeCount = 0;
        selectSlave(0);
        applyStimulus(0, {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 2 * W, 1'b0, miso);
        deselectSlave(0);
        checkOutput("b2b strobes", 128'(strobeCount), 128'(2));
        checkOutput("b2b echo1", 128'(miso[127:64]), 128'(echoModel[0]));
        checkOutput("b2b echo2", 128'(miso[63:0]), 128'(64'h1111_1111_1111_1111));
        dataModel[0] = 64'h2222_2222_2222_2222;
        echoModel[0] = 64'h2222_2222_2222_2222;
        checkOutput("b2b data", 128'(dataOut[0]), 128'(dataModel[0]));

        $display("[TB] aborted frame");
        strobeCount = 0;
        selectSlave(0);
        checkOutput("abort busy", 128'(busyOut[0]), 128'(1));
        applyStimulus(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 13, 1'b0, miso);
        deselectSlave(0);
        checkOutput("abort strobes", 128'(strobeCount), 128'(0));
        checkOutput("abort data", 128'(dataOut[0]), 128'(dataModel[0]));
        checkOutput("abort flag", 128'(frameErrorOut[0]), 128'(EXP_ABORT_FLAG));
        checkOutput("abort idle busy", 128'(busyOut[0]), 128'(0));
        runFrame(0, {$urandom(), $urandom()}, 1'b0, "recover");
        checkOutput("recover flag", 128'(frameErrorOut[0]), 128'(0));

        $display("[TB] glitched SCK");
        runFrame(0, {$urandom(), $urandom()}, 1'b1, "glitch");
        runFrame(3, {$urandom(), $urandom()}, 1'b1, "glitch");

        $display("[TB] reset mid-frame");
        strobeCount = 0;
        selectSlave(0);
        applyStimulus(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 30, 1'b0, miso);
        resetIn = 1'b1;
        #2;
        checkOutput("midreset miso", 128'(misoOut[0]), 128'(0));
        checkOutput("midreset data", 128'(dataOut[0]), 128'(0));
        checkOutput("midreset data m3", 128'(dataOut[3]), 128'(0));
        checkOutput("midreset strobe", 128'(dataReceivedOut[0]), 128'(0));
        checkOutput("midreset busy", 128'(busyOut[0]), 128'(0));
        checkOutput("midreset frameErr", 128'(frameErrorOut[0]), 128'(0));
        for (int m = 0; m < 4; m++) begin
            echoModel[m] = '0;
            dataModel[m] = '0;
        end
        repeat (2) tick(0);
        resetIn = 1'b0;
        deselectSlave(0);
        checkOutput("midreset strobes", 128'(strobeCount), 128'(0));
        runFrame(0, {$urandom(), $urandom()}, 1'b0, "postreset");

        $display("[TB] random frames");
        for (int k = 0; k < 6; k++) begin
            rm = int'($urandom_range(0, 3));
            rw = {$urandom(), $urandom()};
            runFrame(rm, rw, 1'($urandom_range(0, 1)), "random");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
